// File: rtl/sc_score_keeper.sv
// sc_score_keeper
//   Score keeper for one game at a time. Play is armed once level progress
//   reaches a threshold. Each press of the active-low point request adds
//   (current level + 1) to the score, saturating at SCORE_MAX. When the player
//   loses, the final score is folded into the high score. A clear starts a new
//   game and leaves the high score in place.
//
// Ports
//   SC_POINTSCOUNTER_CLOCK_50        in   system clock, rising edge
//   SC_POINTSCOUNTER_RESET_InHigh    in   async reset, active-high
//   SC_SCORE_KEEPER_upCount_inLow    in   point request, one event per high->low
//   SC_SCORE_KEEPER_LevelProgress_In in   level progress, arms play at threshold
//   SC_SCORE_KEEPER_CurrentLvl_In    in   current level, 0-based
//   SC_SCORE_KEEPER_PlayerLose_inLow in   player lost, active-low
//   SC_SCORE_KEEPER_Clear_InHigh     in   synchronous new-game clear
//   SC_SCORE_KEEPER_Score_OutBus     out  current score (registered)
//   SC_SCORE_KEEPER_HighScore_OutBus out  best final score since reset
//   SC_SCORE_KEEPER_Saturated_Out    out  score == SCORE_MAX
//   SC_SCORE_KEEPER_State_Out        out  FSM state
//
// State    | meaning
// IDLE  00 | waiting for level progress to arm play; requests ignored
// RUN   01 | game in progress; requests add points
// GAMEOVER 10 | player lost; score frozen until clear
module sc_score_keeper #(
  parameter int DATAWIDTH_BUS      = 8,
  parameter int SCORE_MAX          = 200,
  parameter int PROGRESS_WIDTH     = 5,
  parameter int PROGRESS_THRESHOLD = 8,
  parameter int LEVEL_WIDTH        = 3
) (
  input  logic                      SC_POINTSCOUNTER_CLOCK_50,
  input  logic                      SC_POINTSCOUNTER_RESET_InHigh,
  input  logic                      SC_SCORE_KEEPER_upCount_inLow,
  input  logic [PROGRESS_WIDTH-1:0] SC_SCORE_KEEPER_LevelProgress_In,
  input  logic [LEVEL_WIDTH-1:0]    SC_SCORE_KEEPER_CurrentLvl_In,
  input  logic                      SC_SCORE_KEEPER_PlayerLose_inLow,
  input  logic                      SC_SCORE_KEEPER_Clear_InHigh,
  output logic [DATAWIDTH_BUS-1:0]  SC_SCORE_KEEPER_Score_OutBus,
  output logic [DATAWIDTH_BUS-1:0]  SC_SCORE_KEEPER_HighScore_OutBus,
  output logic                      SC_SCORE_KEEPER_Saturated_Out,
  output logic [1:0]                SC_SCORE_KEEPER_State_Out
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_GAMEOVER = 2'b10
  } state_t;

  localparam logic [DATAWIDTH_BUS:0]    MAX_EXT = (DATAWIDTH_BUS+1)'(SCORE_MAX);
  localparam logic [DATAWIDTH_BUS-1:0]  MAX_W   = DATAWIDTH_BUS'(SCORE_MAX);
  localparam logic [PROGRESS_WIDTH-1:0] THRESH  = PROGRESS_WIDTH'(PROGRESS_THRESHOLD);

  state_t                   state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] score_q, score_d;
  logic [DATAWIDTH_BUS-1:0] high_q, high_d;
  logic                     prev_up_q, prev_up_d;

  logic                     up_event;
  logic [DATAWIDTH_BUS:0]   sum_ext;

  // One event per falling edge of the request; holding it low does nothing more.
  assign up_event = prev_up_q & ~SC_SCORE_KEEPER_upCount_inLow;

  // Extra bit keeps the carry so saturation compares against the true sum.
  assign sum_ext = {1'b0, score_q}
                 + (DATAWIDTH_BUS+1)'(SC_SCORE_KEEPER_CurrentLvl_In)
                 + (DATAWIDTH_BUS+1)'(1);

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    high_d    = high_q;
    prev_up_d = SC_SCORE_KEEPER_upCount_inLow;

    if (SC_SCORE_KEEPER_Clear_InHigh) begin
      state_d = ST_IDLE;
      score_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (SC_SCORE_KEEPER_LevelProgress_In >= THRESH) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // Losing takes priority over a same-cycle point request.
          if (!SC_SCORE_KEEPER_PlayerLose_inLow) begin
            state_d = ST_GAMEOVER;
            if (score_q > high_q) begin
              high_d = score_q;
            end
          end else if (up_event) begin
            if (sum_ext > MAX_EXT) begin
              score_d = MAX_W;
            end else begin
              score_d = sum_ext[DATAWIDTH_BUS-1:0];
            end
          end
        end
        ST_GAMEOVER: begin
          state_d = ST_GAMEOVER;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge SC_POINTSCOUNTER_CLOCK_50 or posedge SC_POINTSCOUNTER_RESET_InHigh) begin
    if (SC_POINTSCOUNTER_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      score_q   <= '0;
      high_q    <= '0;
      prev_up_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      high_q    <= high_d;
      prev_up_q <= prev_up_d;
    end
  end

  assign SC_SCORE_KEEPER_Score_OutBus     = score_q;
  assign SC_SCORE_KEEPER_HighScore_OutBus = high_q;
  assign SC_SCORE_KEEPER_Saturated_Out    = (score_q == MAX_W);
  assign SC_SCORE_KEEPER_State_Out        = state_q;

endmodule

// File: doc/sc_score_keeper.md
SC_SCORE_KEEPER -- requirements
Module: sc_score_keeper

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 8, width of score and high-score buses.
REQ-002 Parameter SCORE_MAX, default 200, saturation ceiling; SHALL satisfy SCORE_MAX < 2^DATAWIDTH_BUS.
REQ-003 Parameter PROGRESS_WIDTH, default 5, width of level-progress input.
REQ-004 Parameter PROGRESS_THRESHOLD, default 8, progress value that arms scoring.
REQ-005 Parameter LEVEL_WIDTH, default 3, width of current-level input.
REQ-006 SC_POINTSCOUNTER_CLOCK_50  input  1  system clock, rising edge.
REQ-007 SC_POINTSCOUNTER_RESET_InHigh  input  1  reset, asynchronous, active-high.
REQ-008 SC_SCORE_KEEPER_upCount_inLow  input  1  point request, active-low level; one event per high-to-low transition.
REQ-009 SC_SCORE_KEEPER_LevelProgress_In  input  PROGRESS_WIDTH  unsigned level progress.
REQ-010 SC_SCORE_KEEPER_CurrentLvl_In  input  LEVEL_WIDTH  unsigned current level, 0-based.
REQ-011 SC_SCORE_KEEPER_PlayerLose_inLow  input  1  player lost, active-low.
REQ-012 SC_SCORE_KEEPER_Clear_InHigh  input  1  synchronous new-game clear, active-high.
REQ-013 SC_SCORE_KEEPER_Score_OutBus  output  DATAWIDTH_BUS  current score (registered).
REQ-014 SC_SCORE_KEEPER_HighScore_OutBus  output  DATAWIDTH_BUS  best final score since reset (registered).
REQ-015 SC_SCORE_KEEPER_Saturated_Out  output  1  high when score == SCORE_MAX.
REQ-016 SC_SCORE_KEEPER_State_Out  output  2  FSM state: 00 IDLE, 01 RUN, 10 GAMEOVER.

Function
REQ-017 A 1-bit register SHALL hold previous upCount_inLow each cycle; event = prev==1 AND current==0.
REQ-018 FSM IDLE->RUN at the edge where LevelProgress_In >= PROGRESS_THRESHOLD; otherwise stays IDLE.
REQ-019 FSM RUN->GAMEOVER at the edge where PlayerLose_inLow == 0.
REQ-020 FSM GAMEOVER stays GAMEOVER until Clear_InHigh; RUN never returns to IDLE on falling progress.
REQ-021 Clear_InHigh == 1 in any state SHALL, at the next edge: score <= 0, state <= IDLE, high score unchanged; Clear beats every other condition.
REQ-022 Only in RUN, with event and PlayerLose_inLow == 1 and no Clear: score <= min(score + CurrentLvl_In + 1, SCORE_MAX), sum computed in DATAWIDTH_BUS+1 bits.
REQ-023 Events in IDLE or GAMEOVER SHALL be ignored (score held); events in the IDLE->RUN transition cycle ignored.
REQ-024 Event and PlayerLose_inLow == 0 in the same cycle: lose wins, no increment, state -> GAMEOVER.
REQ-025 Latency: score updates at the first rising edge at which upCount_inLow is sampled 0 after a sampled 1; visible on Score_OutBus that cycle onward.
REQ-026 At the RUN->GAMEOVER edge, high score <= max(high score, score); no other update path.
REQ-027 Score held at SCORE_MAX on further events (no wrap); Saturated_Out combinational from registered score.
REQ-028 Held-low upCount_inLow produces exactly one event; no additional events until it returns high.

Reset
REQ-029 Reset asserted: score 0, high score 0, state IDLE, prev-upCount register 1, Saturated_Out 0, immediately and independent of clock.
REQ-030 Reset mid-game SHALL discard all state including high score; first edge after release behaves as from IDLE.

Verification
REQ-031 Defaults; progress=8, lvl=0, five upCount high-low pulses -> state 01, score 5.
REQ-032 RUN, lvl=3, score 198, one pulse -> score 200, Saturated_Out 1; further pulse -> score 200.
REQ-033 RUN score 12, PlayerLose low same cycle as pulse -> score 12, state 10, high score 12; Clear -> score 0, state 00, high 12.
REQ-034 Second game ends at score 7 with high 12 -> high stays 12; game ends at 20 -> high 20.
REQ-035 upCount held low 10 cycles in RUN -> score +1 exactly once; pulses in IDLE (progress 7) -> score 0.
REQ-036 Async reset asserted mid-clock during RUN score 30, high 20 -> all outputs 0, state 00 without clock edge.
